xorshift_arb: RTL and testbench
===============================

XORSHIFT_ARB -- requirements
Module: xorshift_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 16: number of requesters (producer CPUs).
REQ-002 SHALL have parameter DATA_W, default 64: data width per transaction.
REQ-003 SHALL have parameter TXN_PER_REQ, default 1000: transaction quota per requester.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rises on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_vld, input, NUM_REQ bits: per-requester data valid.
REQ-007 SHALL have port req_data, input, NUM_REQ x DATA_W bits: per-requester data.
REQ-008 SHALL have port req_rdy, output, NUM_REQ bits: per-requester accept, one-hot or zero.
REQ-009 SHALL have port out_vld, output, 1 bit: output beat valid.
REQ-010 SHALL have port out_data, output, DATA_W bits: granted data.
REQ-011 SHALL have port out_id, output, $clog2(NUM_REQ) bits: index of source requester.
REQ-012 SHALL have port out_rdy, input, 1 bit: sink accept.
REQ-013 SHALL have port done, output, 1 bit: all quotas met and output drained.

Function
REQ-014 SHALL complete a request transfer on req_vld[i] && req_rdy[i] in the same cycle, and an output transfer on out_vld && out_rdy in the same cycle.
REQ-015 SHALL hold a single registered output slot; slot is free when !out_vld or (out_vld && out_rdy).
REQ-016 SHALL treat requester i as eligible when req_vld[i] is high and cnt[i] < TXN_PER_REQ.
REQ-017 SHALL drive req_rdy combinationally: only when the slot is free, exactly one bit set for the round-robin winner among eligible requesters, else all zero.
REQ-018 SHALL select the winner by round-robin: search starts at ptr, wraps from NUM_REQ-1 to 0; after a grant to i, ptr <= (i+1) mod NUM_REQ; ptr unchanged when no grant.
REQ-019 SHALL load out_data/out_id from the winner and set out_vld the cycle after acceptance (latency 1).
REQ-020 SHALL hold out_vld, out_data, out_id stable while out_vld && !out_rdy.
REQ-021 SHALL clear out_vld after out_rdy when no new grant occurs that cycle; on simultaneous drain and grant, SHALL keep out_vld high with new data (full throughput, one beat per cycle).
REQ-022 SHALL increment cnt[i] on each accepted request from i, saturating at TXN_PER_REQ; requesters at quota receive no further req_rdy.
REQ-023 SHALL assert done, registered, when every cnt[i] == TXN_PER_REQ and out_vld is low; done stays high until reset.
REQ-024 SHALL ignore req_data of non-granted requesters; X on ineligible inputs SHALL NOT propagate.

Reset
REQ-025 SHALL on rst: out_vld=0, out_data=0, out_id=0, done=0, ptr=0, all cnt=0; req_rdy=0 during the rst cycle.
REQ-026 SHALL on reset mid-operation drop any pending output beat and restart quotas from zero.

Structure
REQ-027 SHALL place NUM_REQ default, the id_t typedef (logic [$clog2(NUM_REQ)-1:0]) and the cnt_t counter typedef in package xorshift_arb_pkg.
REQ-028 SHALL implement winner selection in sub-module rr_arbiter (inputs: eligible mask, ptr, enable; outputs: one-hot grant, winner index).

Verification
REQ-029 SHALL verify: all 16 req_vld high, out_rdy=1 -> out_id sequence 0,1,...,15,0 on consecutive cycles, one beat per cycle.
REQ-030 SHALL verify: only requesters 3 and 12 valid, ptr=0 -> grants 3,12,3,12; req_rdy never set for others.
REQ-031 SHALL verify: out_rdy held 0 for 5 cycles with beat id=7 data=0xdeadbeefdeadbef6 -> out signals stable, req_rdy=0, beat delivered once when out_rdy rises.
REQ-032 SHALL verify: TXN_PER_REQ=4, all valid, random out_rdy -> exactly 4 beats per id, then req_rdy=0 and done=1 once last beat drains.
REQ-033 SHALL verify: rst asserted with out_vld=1 -> next cycle out_vld=0, done=0, next grant goes to requester 0.

Source files
------------

// File: rtl/xorshift_arb_pkg.sv
// Shared defaults, index/counter types and a width helper for the xorshift_arb arbiter.
package xorshift_arb_pkg;

    localparam int unsigned DEF_NUM_REQ     = 16;
    localparam int unsigned DEF_DATA_W      = 64;
    localparam int unsigned DEF_TXN_PER_REQ = 1000;

    localparam int unsigned DEF_ID_W  = $clog2(DEF_NUM_REQ);
    localparam int unsigned DEF_CNT_W = $clog2(DEF_TXN_PER_REQ + 1);

    typedef logic [DEF_ID_W-1:0]  id_t;
    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xorshift_arb_rr_arbiter.sv
// Round-robin winner search: first eligible index at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter
    import xorshift_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o_c,
    output logic [ID_W-1:0]    win_o_c
);

    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

    logic            found;
    logic [ID_W-1:0] pos;

    always_comb begin
        grant_o_c = '0;
        win_o_c   = '0;
        found     = 1'b0;
        pos       = ptr_i;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (en_i && !found && elig_i[pos]) begin
                found          = 1'b1;
                grant_o_c[pos] = 1'b1;
                win_o_c        = pos;
            end
            pos = (pos == LAST) ? '0 : pos + ID_W'(1);
        end
    end

endmodule

// File: rtl/xorshift_arb.sv
// Quota-limited round-robin arbiter funnelling NUM_REQ producers into one registered output slot.
module xorshift_arb
    import xorshift_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter  int unsigned DATA_W      = DEF_DATA_W,
    parameter  int unsigned TXN_PER_REQ = DEF_TXN_PER_REQ,
    localparam int unsigned ID_W        = clog2_min1(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_vld,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_rdy,
    output logic                            out_vld,
    output logic [DATA_W-1:0]               out_data,
    output logic [ID_W-1:0]                 out_id,
    input  logic                            out_rdy,
    output logic                            done
);

    localparam int unsigned      CNT_W = $clog2(TXN_PER_REQ + 1);
    localparam logic [ID_W-1:0]  LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] QUOTA = CNT_W'(TXN_PER_REQ);

    logic                            out_vld_q,  out_vld_d;
    logic [DATA_W-1:0]               out_data_q, out_data_d;
    logic [ID_W-1:0]                 out_id_q,   out_id_d;
    logic                            done_q,     done_d;
    logic [ID_W-1:0]                 ptr_q,      ptr_d;
    logic [NUM_REQ-1:0][CNT_W-1:0]   cnt_q,      cnt_d;

    logic [NUM_REQ-1:0] elig_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    win_c;
    logic               arb_en_c;
    logic [DATA_W-1:0]  win_data_c;
    logic               all_full_c;

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            elig_c[i] = req_vld[i] && (cnt_q[i] < QUOTA);
        end
    end

    // No grant while in reset or while the slot holds an undrained beat.
    assign arb_en_c = !rst && (!out_vld_q || out_rdy);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .elig_i    (elig_c),
        .ptr_i     (ptr_q),
        .en_i      (arb_en_c),
        .grant_o_c (grant_c),
        .win_o_c   (win_c)
    );

    assign req_rdy = grant_c;

    // One-hot AND-OR select keeps unknowns on losing inputs out of the slot.
    always_comb begin
        win_data_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_c[i]) begin
                win_data_c = win_data_c | req_data[i];
            end
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        all_full_c = 1'b1;

        if (|grant_c) begin
            out_vld_d     = 1'b1;
            out_data_d    = win_data_c;
            out_id_d      = win_c;
            ptr_d         = (win_c == LAST) ? '0 : win_c + ID_W'(1);
            cnt_d[win_c]  = cnt_q[win_c] + CNT_W'(1);
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (cnt_d[i] != QUOTA) begin
                all_full_c = 1'b0;
            end
        end
        done_d = done_q || (all_full_c && !out_vld_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= '0;
            done_q     <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            done_q     <= done_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_id   = out_id_q;
    assign done     = done_q;

endmodule

// File: tb/tb_xorshift_arb.sv
// Randomized bench for xorshift_arb against a queue/array-level reference model.
module tb_xorshift_arb;

    localparam int N  = 16;
    localparam int DW = 64;
    localparam int Q  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N-1:0]            req_vld = '0;
    logic [N-1:0][DW-1:0]    req_data = '0;
    logic [N-1:0]            req_rdy;
    logic                    out_vld;
    logic [DW-1:0]           out_data;
    logic [3:0]              out_id;
    logic                    out_rdy = 1'b0;
    logic                    done;

    xorshift_arb #(
        .NUM_REQ     (N),
        .DATA_W      (DW),
        .TXN_PER_REQ (Q)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_id   (out_id),
        .out_rdy  (out_rdy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_cnt [N];
    int          m_ptr  = 0;
    bit          m_vld  = 1'b0;
    logic [63:0] m_data = '0;
    int          m_id   = 0;
    bit          m_done = 1'b0;

    int          cyc = 0;
    int          acc_ids [$];
    int          acc_cyc [$];
    logic [63:0] acc_data [$];
    int          grant_ids [$];
    logic [N-1:0] rdy_or = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, log transfers, then advance the model.
    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_rdy;
        int w;
        int full;
        chk("out_vld", 64'(out_vld), 64'(m_vld));
        if (m_vld) begin
            chk("out_data", 64'(out_data), m_data);
            chk("out_id", 64'(out_id), 64'(m_id));
        end
        chk("done", 64'(done), 64'(m_done));

        exp_rdy = '0;
        w = -1;
        if (!rst && (!m_vld || out_rdy)) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (w < 0 && req_vld[idx] && m_cnt[idx] < Q) w = idx;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));

        rdy_or = rdy_or | req_rdy;
        if (out_vld && out_rdy) begin
            acc_ids.push_back(int'(out_id));
            acc_cyc.push_back(cyc);
            acc_data.push_back(out_data);
        end
        for (int i = 0; i < N; i++) begin
            if (req_rdy[i] && req_vld[i]) grant_ids.push_back(i);
        end

        if (rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ptr = 0; m_vld = 1'b0; m_data = '0; m_id = 0; m_done = 1'b0;
        end else begin
            if (w >= 0) begin
                m_vld = 1'b1;
                m_data = req_data[w];
                m_id = w;
                m_ptr = (w + 1) % N;
                m_cnt[w] = m_cnt[w] + 1;
            end else if (out_rdy) begin
                m_vld = 1'b0;
            end
            full = 1;
            for (int i = 0; i < N; i++) if (m_cnt[i] != Q) full = 0;
            m_done = m_done || (full == 1 && !m_vld);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i] = {$urandom(), $urandom()};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        out_rdy = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        acc_ids.delete();
        acc_cyc.delete();
        acc_data.delete();
        grant_ids.delete();
        rdy_or = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        step();

        // reset values, then full-rate sweep 0..15,0
        do_reset();
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        clear_logs();
        req_vld = '1;
        out_rdy = 1'b1;
        repeat (18) begin
            rand_data();
            step();
        end
        req_vld = '0;
        step();
        step();
        chk("sweep_beats", 64'(acc_ids.size() >= 17), 64'd1);
        for (int k = 0; k < 17 && k < acc_ids.size(); k++) begin
            chk("sweep_id", 64'(acc_ids[k]), 64'(k % 16));
            chk("sweep_cycle", 64'(acc_cyc[k] - acc_cyc[0]), 64'(k));
        end

        // only requesters 3 and 12 valid
        do_reset();
        clear_logs();
        rand_data();
        req_vld = 16'h1008;
        out_rdy = 1'b1;
        repeat (4) step();
        req_vld = '0;
        step();
        step();
        chk("pair_grants", 64'(grant_ids.size()), 64'd4);
        if (grant_ids.size() == 4) begin
            chk("pair_g0", 64'(grant_ids[0]), 64'd3);
            chk("pair_g1", 64'(grant_ids[1]), 64'd12);
            chk("pair_g2", 64'(grant_ids[2]), 64'd3);
            chk("pair_g3", 64'(grant_ids[3]), 64'd12);
        end
        chk("pair_others", 64'(rdy_or & ~16'h1008), 64'd0);

        // back-pressure hold of a single beat
        do_reset();
        clear_logs();
        req_vld = 16'h0080;
        req_data[7] = 64'hdeadbeefdeadbef6;
        out_rdy = 1'b0;
        step();
        req_data[7] = 64'h0123456789abcdef;
        repeat (5) begin
            @(negedge clk);
            chk("hold_vld", 64'(out_vld), 64'd1);
            chk("hold_id", 64'(out_id), 64'd7);
            chk("hold_data", 64'(out_data), 64'hdeadbeefdeadbef6);
            chk("hold_rdy", 64'(req_rdy), 64'd0);
            @(posedge clk);
            #1;
        end
        req_vld = '0;
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        step();
        step();
        n = 0;
        foreach (acc_data[k]) if (acc_data[k] == 64'hdeadbeefdeadbef6) n++;
        chk("hold_delivered_once", 64'(n), 64'd1);
        chk("hold_total_beats", 64'(acc_data.size()), 64'd1);

        // quota exhaustion under random out_rdy
        do_reset();
        clear_logs();
        req_vld = '1;
        n = 0;
        while (!done && n < 600) begin
            rand_data();
            out_rdy = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("quota_done", 64'(done), 64'd1);
        chk("quota_out_vld", 64'(out_vld), 64'd0);
        for (int i = 0; i < N; i++) begin
            int c;
            c = 0;
            foreach (acc_ids[k]) if (acc_ids[k] == i) c++;
            chk("quota_beats", 64'(c), 64'(Q));
        end
        repeat (5) begin
            out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("quota_no_rdy", 64'(req_rdy), 64'd0);
            chk("quota_done_sticky", 64'(done), 64'd1);
            @(posedge clk);
            #1;
        end

        // reset while a beat is pending
        do_reset();
        chk("rst_clears_done", 64'(done), 64'd0);
        req_vld = '1;
        rand_data();
        out_rdy = 1'b0;
        repeat (3) step();
        chk("pend_vld", 64'(out_vld), 64'd1);
        rst = 1'b1;
        step();
        chk("midrst_vld", 64'(out_vld), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;
        out_rdy = 1'b1;
        clear_logs();
        step();
        step();
        chk("midrst_first_grant_seen", 64'(grant_ids.size() > 0), 64'd1);
        if (grant_ids.size() > 0) chk("midrst_first_grant", 64'(grant_ids[0]), 64'd0);

        // free-running random traffic with occasional reset
        do_reset();
        repeat (400) begin
            rand_data();
            req_vld = N'($urandom());
            out_rdy = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        req_vld = '0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
